// File: rtl/f_pc_sequencer.sv
// f_pc_sequencer - fetch-stage next-PC scheduler for the pipelined MIPS core.
//
// Owns the architectural fetch PC. Each cycle it selects the next PC from one of
// four sources: exception entry, eret return, branch/jump target, or the
// sequential PC+4. It runs a req/ready handshake with instruction memory. It also
// holds a pending branch target, so the delay-slot fetch in flight completes
// before the fetch stream redirects. A fetch address error (AdEL) on a slot does
// not go to memory. The slot completes at once and carries the AdEL flag down
// the pipe.
//
// Optional feature macro: F_PC_SEQ_PERF_EN. When it is defined, the block adds
// two saturating performance counters, perf_wait and perf_redir.
//
// Ports:
//   clk          in   1   clock, all state on posedge
//   reset        in   1   synchronous, active-high
//   stall        in   1   F/D register cannot accept; hold current fetch
//   br_valid     in   1   one-cycle redirect pulse from D stage
//   br_target    in   32  branch/jump target
//   ex_req       in   1   exception/interrupt flush from CP0
//   eret_req     in   1   eret flush
//   epc          in   32  return address for eret
//   imem_req     out  1   fetch request valid
//   imem_addr    out  32  fetch address (= pc_q)
//   imem_ready   in   1   memory data valid this cycle for imem_addr
//   fetch_valid  out  1   slot accepted into F/D this cycle
//   fetch_pc     out  32  PC of accepted slot (= pc_q)
//   fetch_adel   out  1   accepted slot carries AdEL
//   perf_wait    out  32  (F_PC_SEQ_PERF_EN) cycles with imem_req & ~imem_ready
//   perf_redir   out  32  (F_PC_SEQ_PERF_EN) applied redirects

module f_pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI    = 32'h0000_6FFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        ex_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic        fetch_adel
`ifdef F_PC_SEQ_PERF_EN
  ,
  output logic [31:0] perf_wait,
  output logic [31:0] perf_redir
`endif
);

  typedef enum logic [0:0] {
    StSeq,   // sequential fetch, no redirect pending
    StPend   // branch seen while delay slot still in flight; target held in pend_q
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;

  logic adel;
  logic done;
  logic flush;
  logic redir;

  // Address check on the current fetch PC. A bad address never reaches memory.
  assign adel = (pc_q[1:0] != 2'b00) | (pc_q < TEXT_LO) | (pc_q > TEXT_HI);

  assign imem_req  = ~adel & ~reset;
  assign imem_addr = pc_q;

  // An AdEL slot completes without waiting on the memory.
  assign done  = (adel | imem_ready) & ~stall;
  assign flush = ex_req | eret_req;

  assign fetch_valid = done & ~flush;
  assign fetch_pc    = pc_q;
  assign fetch_adel  = adel & fetch_valid;

  // Next-PC select. A flush ignores stall and abandons the fetch in flight.
  always_comb begin
    pc_d  = pc_q;
    redir = 1'b0;
    if (ex_req) begin
      pc_d  = EXC_VECTOR;
      redir = 1'b1;
    end else if (eret_req) begin
      pc_d  = epc;
      redir = 1'b1;
    end else if (done && br_valid) begin
      // Delay slot completes this cycle, so the target goes straight to the PC.
      pc_d  = br_target;
      redir = 1'b1;
    end else if (done && (state_q == StPend)) begin
      pc_d  = pend_q;
      redir = 1'b1;
    end else if (done) begin
      pc_d  = pc_q + 32'd4;  // wraps modulo 2^32; the wrapped value fails the range check
    end
  end

  // Pending-branch state machine.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    unique case (state_q)
      StSeq: begin
        if (br_valid && !done && !flush) begin
          state_d = StPend;
          pend_d  = br_target;
        end
      end
      StPend: begin
        if (done || flush) begin
          state_d = StSeq;
        end else if (br_valid) begin
          // A branch in the delay slot is architecturally undefined. The newest target wins.
          pend_d = br_target;
        end
      end
      default: state_d = StSeq;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      state_q <= StSeq;
      pend_q  <= 32'h0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

`ifdef F_PC_SEQ_PERF_EN
  logic [31:0] perf_wait_q;
  logic [31:0] perf_redir_q;

  // Both counters saturate instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_wait_q  <= 32'h0;
      perf_redir_q <= 32'h0;
    end else begin
      if (imem_req && !imem_ready && (perf_wait_q != 32'hFFFF_FFFF)) begin
        perf_wait_q <= perf_wait_q + 32'd1;
      end
      if (redir && (perf_redir_q != 32'hFFFF_FFFF)) begin
        perf_redir_q <= perf_redir_q + 32'd1;
      end
    end
  end

  assign perf_wait  = perf_wait_q;
  assign perf_redir = perf_redir_q;
`else
  logic unused_redir;
  assign unused_redir = redir;
`endif

endmodule
